// File: rtl/matmul_reg_bank.sv
// matmul_reg_bank: register bank for a matmul core (CTRL, A/B operands, FLAGS, scratchpad, clear engine)
// Optional FLAGS_W1C_EN: FLAGS writes clear bits written as 1.
module matmul_reg_bank #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [BUS_WIDTH-1:0]            wdata_i,
  input  logic                            write_i,
  input  logic                            read_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] strb_i,
  output logic [BUS_WIDTH-1:0]            rdata_o,
  output logic                            mem_busy_o,
  output logic [BUS_WIDTH-1:0]            ctrl_o,
  output logic                            start_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] a_flat_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] b_flat_o,
  input  logic                            sp_we_i,
  input  logic [1:0]                      sp_target_i,
  input  logic [1:0]                      sp_row_i,
  input  logic [BUS_WIDTH-1:0]            sp_wdata_i,
  input  logic                            done_i,
  input  logic                            ovf_i
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, CLEAR, START_PEND} state_t;
  state_t state_q, state_d;
  logic [BUS_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] a_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] sp_q [SP_NTARGETS][MAX_DIM];
  logic [BUS_WIDTH-1:0] sp_d [SP_NTARGETS][MAX_DIM];
  logic [1:0] clr_row_q, clr_row_d, clr_tgt_q, clr_tgt_d;
  logic pend_q, pend_d, done_q, done_d, ovf_q, ovf_d;
  logic [BUS_WIDTH-1:0] wmask, flags;
  logic [4:0] sel;
  logic [1:0] row, w1c;
  logic wr_ctrl, wr_a, wr_b, unused_addr;
  assign sel         = addr_i[4:0];
  assign row         = addr_i[6:5];
  assign unused_addr = ^addr_i[ADDR_WIDTH-1:7];
  assign wr_ctrl     = write_i && sel == 5'h00;
  assign wr_a        = write_i && sel == 5'h04;
  assign wr_b        = write_i && sel == 5'h08;
  assign flags       = {{(BUS_WIDTH-2){1'b0}}, ovf_q, done_q};
  assign start_o     = state_q == START_PEND;
  assign mem_busy_o  = state_q == CLEAR;
  assign ctrl_o      = ctrl_q;
`ifdef FLAGS_W1C_EN
  assign w1c = (write_i && sel == 5'h0C && strb_i[0]) ? wdata_i[1:0] : 2'b00;
`else
  assign w1c = 2'b00;
`endif
  for (genvar r = 0; r < MAX_DIM; r++) begin : g_flat
    assign a_flat_o[r*BUS_WIDTH +: BUS_WIDTH] = a_q[r];
    assign b_flat_o[r*BUS_WIDTH +: BUS_WIDTH] = b_q[r];
  end
  always_comb begin
    wmask = '0;
    for (int j = 0; j < MAX_DIM; j++) wmask[j*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{strb_i[j]}};
  end
  always_comb begin
    ctrl_d = {ctrl_q[BUS_WIDTH-1:2], 2'b00};
    if (wr_ctrl) ctrl_d = (ctrl_d & ~wmask) | (wdata_i & wmask);
    a_d = a_q;
    if (wr_a) a_d[row] = (a_q[row] & ~wmask) | (wdata_i & wmask);
    b_d = b_q;
    if (wr_b) b_d[row] = (b_q[row] & ~wmask) | (wdata_i & wmask);
    // the clear engine is applied last so it wins a same-row collision
    sp_d = sp_q;
    if (sp_we_i) sp_d[sp_target_i][sp_row_i] = sp_wdata_i;
    if (state_q == CLEAR) sp_d[clr_tgt_q][clr_row_q] = '0;
    done_d = done_i | (done_q & ~start_o & ~w1c[0]);
    ovf_d  = ovf_i | (ovf_q & ~start_o & ~w1c[1]);
    state_d   = state_q;
    clr_row_d = clr_row_q;
    clr_tgt_d = clr_tgt_q;
    pend_d    = pend_q;
    if (state_q == IDLE && wr_ctrl && strb_i[0]) begin
      if (wdata_i[1]) begin
        state_d   = CLEAR;
        clr_row_d = 2'd0;
        clr_tgt_d = wdata_i[3:2];
        pend_d    = wdata_i[0];
      end else if (wdata_i[0]) state_d = START_PEND;
    end else if (state_q == CLEAR) begin
      clr_row_d = clr_row_q + 2'd1;
      if (clr_row_q == 2'(MAX_DIM-1)) begin
        state_d = pend_q ? START_PEND : IDLE;
        pend_d  = 1'b0;
      end
    end else if (state_q == START_PEND) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      sp_q      <= '{default: '{default: '0}};
      clr_row_q <= '0;
      clr_tgt_q <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sp_q      <= sp_d;
      clr_row_q <= clr_row_d;
      clr_tgt_q <= clr_tgt_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end
  always_comb begin
    rdata_o = '0;
    if (read_i)
      rdata_o = sel == 5'h00 ? ctrl_q :
                sel == 5'h04 ? a_q[row] :
                sel == 5'h08 ? b_q[row] :
                sel == 5'h0C ? flags :
                (sel[4] && sel[1:0] == 2'b00) ? sp_q[sel[3:2]][row] : '0;
  end
endmodule
